// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams WORDS limbs, LSB first, through one
// external W-bit combinational adder and chains the carry between limbs.
module mp_add_sequencer #(
  parameter int unsigned W     = 32,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*WORDS-1:0]   a_in,
  input  logic [W*WORDS-1:0]   b_in,
  input  logic                 cin,
  input  logic                 sub,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*WORDS-1:0]   sum_out,
  output logic                 cout_out,
  output logic                 overflow
);

  localparam int unsigned N     = W * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic             carry;
  logic             last_limb;

  assign last_limb = (idx == IDX_W'(WORDS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // b_reg holds the effective operand (already inverted for subtraction), so the
  // overflow test below compares against the B that actually entered the adder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= sub ? ~b_in : b_in;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_out[idx*W +: W] <= add_sum;
          carry               <= add_cout;
          if (last_limb) begin
            idx      <= '0;
            cout_out <= add_cout;
            overflow <= (a_reg[N-1] == b_reg[N-1]) && (add_sum[W-1] != a_reg[N-1]);
            state    <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx*W +: W];
      add_b   = b_reg[idx*W +: W];
      add_cin = carry;
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer (W=32, WORDS=4) with a behavioural external adder.
module tb_mp_add_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned WORDS = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   a_in;
  logic [127:0]   b_in;
  logic           cin;
  logic           sub;
  logic [31:0]    add_a;
  logic [31:0]    add_b;
  logic           add_cin;
  logic [31:0]    add_sum;
  logic           add_cout;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   sum_out;
  logic           cout_out;
  logic           overflow;
  logic [32:0]    adder_full;

  always #5 clk = ~clk;

  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_sum    = adder_full[31:0];
  assign add_cout   = adder_full[32];

  mp_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .sub(sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out), .overflow(overflow)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [127:0] a, input logic [127:0] b, input logic c, input logic s);
    a_in = a; b_in = b; cin = c; sub = s; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts RUN cycles until out_valid and records add_cin per limb (bit i = limb i).
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic c,
                        input logic s, output int cycles, output logic [3:0] cins);
    start_op(a, b, c, s);
    cycles = 0;
    cins   = '0;
    while (!out_valid && cycles < 12) begin
      if (cycles < 4) cins[cycles] = add_cin;
      cycles++;
      @(posedge clk); #1;
    end
    check("out_valid_reached", out_valid, 1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  int           cyc_n;
  logic [3:0]   cins;
  logic [127:0] hold_sum;
  logic [127:0] sa [3];
  logic [127:0] sb [3];
  logic         sc [3];
  logic         ss [3];
  logic [127:0] es [3];
  logic         ec [3];
  int           acc_cyc [3];
  int           n_acc;
  int           n_res;
  int           cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum_out, 0);
    check("rst_cout", cout_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_add_bus", {add_a, add_b, add_cin}, 0);

    // 1: all-ones + 1 wraps to zero with carry out
    run_op({128{1'b1}}, 128'd1, 1'b0, 1'b0, cyc_n, cins);
    check("t1_run_cycles", cyc_n, 4);
    check("t1_cin_seq", cins, 4'b1110);
    check("t1_sum", sum_out, 0);
    check("t1_cout", cout_out, 1);
    check("t1_ovf", overflow, 0);
    check("t1_add_bus_done", {add_a, add_b, add_cin}, 0);
    finish_op();

    // 2: 5 - 7 borrows; cin must be ignored in subtract mode
    run_op(128'd5, 128'd7, 1'b0, 1'b1, cyc_n, cins);
    check("t2_sum", sum_out, {{124{1'b1}}, 4'hE});
    check("t2_cout", cout_out, 0);
    check("t2_ovf", overflow, 0);
    check("t2_cin_seq", cins, 4'b0001);
    finish_op();

    // 3: max positive + 1 overflows to most negative
    run_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, cyc_n, cins);
    check("t3_sum", sum_out, {1'b1, 127'd0});
    check("t3_cout", cout_out, 0);
    check("t3_ovf", overflow, 1);

    // 4: consumer stalls; results hold and new inputs are refused
    hold_sum = {1'b1, 127'd0};
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      a_in = 128'hDEAD; b_in = 128'hBEEF;
      @(posedge clk); #1;
      check("t4_out_valid_hold", out_valid, 1);
      check("t4_in_ready_low", in_ready, 0);
      check("t4_sum_hold", sum_out, hold_sum);
      check("t4_cout_hold", cout_out, 0);
    end
    in_valid = 1'b0;
    finish_op();

    // 5: reset on the second RUN cycle aborts the op
    start_op(128'h1234_5678_9ABC_DEF0_1111_2222_3333_4444, 128'h55, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_sum", sum_out, 0);
    check("t5_add_bus", {add_a, add_b, add_cin}, 0);
    cyc_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) cyc_n++;
    end
    check("t5_no_result", cyc_n, 0);

    // 6: back-to-back ops with in_valid/out_ready held high
    sa[0] = 128'd1;           sb[0] = 128'd2; sc[0] = 1'b0; ss[0] = 1'b0;
    es[0] = 128'd3;           ec[0] = 1'b0;
    sa[1] = 128'hFFFF_FFFF;   sb[1] = 128'd1; sc[1] = 1'b1; ss[1] = 1'b0;
    es[1] = 128'h1_0000_0001; ec[1] = 1'b0;
    sa[2] = 128'd10;          sb[2] = 128'd3; sc[2] = 1'b0; ss[2] = 1'b1;
    es[2] = 128'd7;           ec[2] = 1'b1;
    n_acc = 0; n_res = 0; cyc = 0;
    a_in = sa[0]; b_in = sb[0]; cin = sc[0]; sub = ss[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_res < 3 && cyc < 60) begin
      @(negedge clk);
      if (in_valid && in_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid) begin
        check("t6_sum", sum_out, es[n_res]);
        check("t6_cout", cout_out, ec[n_res]);
        n_res++;
      end
      @(posedge clk); #1;
      if (n_acc < 3) begin
        a_in = sa[n_acc]; b_in = sb[n_acc]; cin = sc[n_acc]; sub = ss[n_acc];
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    out_ready = 1'b0;
    check("t6_results", n_res, 3);
    check("t6_accepts", n_acc, 3);
    if (n_acc == 3) begin
      check("t6_gap01", acc_cyc[1] - acc_cyc[0], 6);
      check("t6_gap12", acc_cyc[2] - acc_cyc[1], 6);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
